// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: queue entry width and entry type.
package rv32i_types;

  localparam int unsigned QUEUE_DATA_WIDTH = 32;

  typedef logic [QUEUE_DATA_WIDTH-1:0] queue_entry_t;

endpackage

// File: rtl/dq_skid_buf.sv
// Small power-of-two FIFO with combinational head read, used as the dequeue skid buffer.
module dq_skid_buf
  import rv32i_types::*;
#(
  parameter int unsigned DATA_WIDTH = QUEUE_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head_data,
  output logic [$clog2(BUF_DEPTH):0]   occ,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);

  logic [AW:0]           head_q, head_d;
  logic [AW:0]           tail_q, tail_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic                  full;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign empty     = (head_q == tail_q);
  assign occ       = tail_q - head_q;
  assign head_data = mem_q[head_q[AW-1:0]];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;
    if (clr) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[tail_q[AW-1:0]] = push_data;
        tail_d                = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/queue_dequeue_ctrl.sv
// Consumer-side dequeue controller: credit-based issue to a registered-read queue,
// skid-buffered capture, valid/ready presentation downstream.
module queue_dequeue_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned DATA_WIDTH = QUEUE_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  q_empty,
  output logic                  q_dequeue,
  input  logic [DATA_WIDTH-1:0] q_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic          inflight_q, inflight_d;
  logic [CW-1:0] occ;
  logic          buf_empty;
  logic          pop;
  logic          push;
  logic [CW:0]   committed;
  logic          credit_ok;

  assign out_valid = !buf_empty;

  // Entries already owned by the buffer (stored or returning) bound further issue;
  // a same-cycle pop frees one slot so the full case can still stream.
  always_comb begin
    pop        = out_valid && out_ready && !flush;
    push       = inflight_q && !flush;
    committed  = {1'b0, occ} + (CW+1)'(inflight_q);
    credit_ok  = (committed < (CW+1)'(BUF_DEPTH))
              || ((committed == (CW+1)'(BUF_DEPTH)) && pop);
    q_dequeue  = !rst && !flush && !q_empty && credit_ok;
    inflight_d = q_dequeue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  dq_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push),
    .push_data (q_rdata),
    .pop       (pop),
    .head_data (out_data),
    .occ       (occ),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_queue_dequeue_ctrl.sv
// Directed and random checks of queue_dequeue_ctrl against an entry-level reference model.
module tb_queue_dequeue_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          q_empty = 1'b1;
  logic          q_dequeue;
  logic [DW-1:0] q_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  queue_dequeue_ctrl #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .q_empty   (q_empty),
    .q_dequeue (q_dequeue),
    .q_rdata   (q_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  logic [31:0] qmem [$];
  logic [31:0] mfifo [$];
  logic [31:0] sent [$];
  logic [31:0] got [$];
  bit          pend;
  logic [31:0] pend_data;
  bit          rst_prev;
  bit          record;
  int          n_checks;
  int          n_fail;

  // Queue with registered read; garbage on rdata whenever no dequeue was accepted.
  always @(posedge clk) begin
    if (rst || flush) begin
      qmem.delete();
      q_rdata <= $urandom;
    end else if (q_dequeue && qmem.size() > 0) begin
      q_rdata <= qmem.pop_front();
    end else begin
      q_rdata <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input logic [31:0] v);
    qmem.push_back(v);
    if (record) sent.push_back(v);
  endtask

  task automatic evaluate();
    bit exp_valid, exp_pop, exp_deq;
    int after;
    exp_valid = (mfifo.size() != 0);
    exp_pop   = exp_valid && out_ready && !flush && !rst;
    after     = mfifo.size() + int'(pend) - int'(exp_pop);
    exp_deq   = !rst && !flush && (qmem.size() != 0) && (after < DEPTH);

    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) check("out_data", out_data, mfifo[0]);
    if (rst_prev)  check("out_data_after_rst", out_data, 32'h0);
    check("q_dequeue", 32'(q_dequeue), 32'(exp_deq));
    check("occ", 32'(dut.u_buf.occ), 32'(mfifo.size()));
    check("deq_while_empty", 32'(q_dequeue & q_empty), 32'h0);
    check("capture_when_full", 32'(dut.u_buf.push & dut.u_buf.full), 32'h0);
    check("pop_when_empty", 32'(dut.u_buf.pop & dut.u_buf.empty), 32'h0);

    if (record && out_valid && out_ready && !flush && !rst) got.push_back(out_data);

    if (rst || flush) begin
      mfifo.delete();
      pend = 1'b0;
    end else begin
      if (exp_pop) void'(mfifo.pop_front());
      if (pend) mfifo.push_back(pend_data);
      pend = exp_deq;
      if (exp_deq) pend_data = qmem[0];
    end
    rst_prev = rst;
  endtask

  task automatic step(input bit r, input bit f, input bit rdy);
    @(negedge clk);
    rst       = r;
    flush     = f;
    out_ready = rdy;
    q_empty   = (qmem.size() == 0);
    #1;
    evaluate();
  endtask

  initial begin
    int cycles;
    int pushed;
    int bad;
    n_checks = 0;
    n_fail   = 0;
    pend     = 1'b0;
    rst_prev = 1'b0;
    record   = 1'b0;

    step(1, 0, 1);
    step(1, 0, 1);

    // Three preloaded entries streamed with out_ready high.
    enqueue(32'h11); enqueue(32'h22); enqueue(32'h33);
    repeat (7) step(0, 0, 1);

    // Backpressure: five entries, only BUF_DEPTH taken, then released.
    for (int i = 1; i <= 5; i++) enqueue(32'h100 + 32'(i));
    repeat (6) step(0, 0, 0);
    check("bp_occ_full", 32'(dut.u_buf.occ), 32'(DEPTH));
    check("bp_head_stable", out_data, 32'h101);
    repeat (9) step(0, 0, 1);

    // Flush the cycle after 0xAA is dequeued; 0xBB follows normally.
    enqueue(32'hAA);
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    enqueue(32'hBB);
    repeat (5) step(0, 0, 1);

    // Queue alternately empty and holding a single entry.
    for (int v = 1; v <= 8; v++) begin
      enqueue(32'(v));
      repeat (3) step(0, 0, 1);
    end

    // Reset with one buffered and one in-flight entry.
    for (int i = 0; i < 4; i++) enqueue(32'h200 + 32'(i));
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_q_dequeue", 32'(q_dequeue), 32'h0);
    repeat (2) step(0, 0, 1);

    // Random backpressure and arrivals over 1000 unique entries.
    record = 1'b1;
    cycles = 0;
    pushed = 0;
    while (cycles < 20000 &&
           (pushed < 1000 || mfifo.size() != 0 || pend || qmem.size() != 0)) begin
      if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
        enqueue(32'h1000_0000 + 32'(pushed));
        pushed++;
      end
      step(0, 0, 1'($urandom_range(0, 1)));
      cycles++;
    end
    repeat (3) step(0, 0, 1);
    check("rand_within_budget", 32'(cycles < 20000), 32'h1);
    check("rand_count", 32'(got.size()), 32'(sent.size()));
    bad = 0;
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      if (got[i] !== sent[i]) bad++;
    end
    check("rand_order", 32'(bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
